// File: rtl/dog_pyramid_stream.sv
// Difference-of-Gaussian stream stage: NUM_SCALES blurred pixels in,
// NUM_SCALES-1 DoG pixels out (G[k+1]-G[k]), two-stage elastic pipeline
// with signed or magnitude output, saturation flag and frame markers.
module dog_pyramid_stream #(
  parameter int NUM_SCALES = 4,
  parameter int DATA_W     = 9,
  parameter int OUT_W      = 10,
  parameter int ABS_MODE   = 0
) (
  input  logic                              iclk,
  input  logic                              irst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [NUM_SCALES*DATA_W-1:0]      in_data,
  input  logic                              in_sof,
  input  logic                              in_eol,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [(NUM_SCALES-1)*OUT_W-1:0]   out_data,
  output logic                              out_sof,
  output logic                              out_eol,
  output logic                              out_sat,
  output logic [15:0]                       frame_cnt
);

  localparam int NCH  = NUM_SCALES - 1;
  localparam int DW   = DATA_W + 1;
  // Working width holds any difference, its negation and every clamp bound.
  localparam int WIDE = ((OUT_W > DW) ? OUT_W : DW) + 2;

  localparam logic signed [WIDE-1:0] ONE   = WIDE'(1);
  localparam logic signed [WIDE-1:0] S_MAX = (ONE <<< (OUT_W - 1)) - ONE;
  localparam logic signed [WIDE-1:0] S_MIN = -(ONE <<< (OUT_W - 1));
  localparam logic signed [WIDE-1:0] U_MAX = (ONE <<< OUT_W) - ONE;

  // Stage 1: raw signed differences
  logic                    v1_q, v1_d;
  logic [NCH*DW-1:0]       diff_q, diff_d;
  logic                    sof1_q, sof1_d;
  logic                    eol1_q, eol1_d;

  // Stage 2: formatted result
  logic                    v2_q, v2_d;
  logic [NCH*OUT_W-1:0]    data2_q, data2_d;
  logic                    sof2_q, sof2_d;
  logic                    eol2_q, eol2_d;
  logic                    sat2_q, sat2_d;

  logic [15:0]             fcnt_q, fcnt_d;

  logic                    s1_rdy, s2_rdy, in_fire, s1_adv;
  logic [NCH*DW-1:0]       diff_raw;
  logic [NCH*OUT_W-1:0]    fmt_data;
  logic                    fmt_sat;
  logic signed [WIDE-1:0]  fmt_w;

  // Elastic handshake: each stage can load whenever it is empty or draining
  always_comb begin
    s2_rdy  = !v2_q | out_ready;
    s1_rdy  = !v1_q | s2_rdy;
    in_fire = in_valid & s1_rdy;
    s1_adv  = v1_q & s2_rdy;
  end

  // Per-channel difference of adjacent scales, zero-extended to DATA_W+1 bits
  always_comb begin
    diff_raw = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      diff_raw[k*DW +: DW] = {1'b0, in_data[(k+1)*DATA_W +: DATA_W]}
                           - {1'b0, in_data[k*DATA_W +: DATA_W]};
    end
  end

  // Output formatting: a single clamp path covers both the wide case
  // (bounds never reached, plain sign extension) and the narrow case.
  always_comb begin
    fmt_data = '0;
    fmt_sat  = 1'b0;
    fmt_w    = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      fmt_w = WIDE'($signed(diff_q[k*DW +: DW]));
      if (ABS_MODE != 0) begin
        if (fmt_w[WIDE-1]) fmt_w = -fmt_w;
        if (fmt_w > U_MAX) begin
          fmt_w   = U_MAX;
          fmt_sat = 1'b1;
        end
      end else begin
        if (fmt_w > S_MAX) begin
          fmt_w   = S_MAX;
          fmt_sat = 1'b1;
        end else if (fmt_w < S_MIN) begin
          fmt_w   = S_MIN;
          fmt_sat = 1'b1;
        end
      end
      fmt_data[k*OUT_W +: OUT_W] = fmt_w[OUT_W-1:0];
    end
  end

  // Next-state for both pipeline stages and the accepted-sof counter
  always_comb begin
    v1_d    = v1_q;
    diff_d  = diff_q;
    sof1_d  = sof1_q;
    eol1_d  = eol1_q;
    v2_d    = v2_q;
    data2_d = data2_q;
    sof2_d  = sof2_q;
    eol2_d  = eol2_q;
    sat2_d  = sat2_q;
    fcnt_d  = fcnt_q;
    if (s1_rdy) v1_d = in_valid;
    if (in_fire) begin
      diff_d = diff_raw;
      sof1_d = in_sof;
      eol1_d = in_eol;
      if (in_sof) fcnt_d = fcnt_q + 16'd1;
    end
    if (s2_rdy) v2_d = v1_q;
    if (s1_adv) begin
      data2_d = fmt_data;
      sof2_d  = sof1_q;
      eol2_d  = eol1_q;
      sat2_d  = fmt_sat;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge iclk) begin
    if (irst) begin
      v1_q    <= 1'b0;
      diff_q  <= '0;
      sof1_q  <= 1'b0;
      eol1_q  <= 1'b0;
      v2_q    <= 1'b0;
      data2_q <= '0;
      sof2_q  <= 1'b0;
      eol2_q  <= 1'b0;
      sat2_q  <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      v1_q    <= v1_d;
      diff_q  <= diff_d;
      sof1_q  <= sof1_d;
      eol1_q  <= eol1_d;
      v2_q    <= v2_d;
      data2_q <= data2_d;
      sof2_q  <= sof2_d;
      eol2_q  <= eol2_d;
      sat2_q  <= sat2_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Reset forces ready so upstream never sees a stall while flushing
  assign in_ready  = s1_rdy | irst;
  assign out_valid = v2_q;
  assign out_data  = data2_q;
  assign out_sof   = sof2_q;
  assign out_eol   = eol2_q;
  assign out_sat   = sat2_q;
  assign frame_cnt = fcnt_q;

endmodule

// File: tb/tb_dog_pyramid_stream.sv
// Bench for dog_pyramid_stream: three instances (signed OUT_W=10, signed
// OUT_W=8, magnitude OUT_W=8) share one input stream and out_ready.
module tb_dog_pyramid_stream;

  logic        clk = 1'b0;
  logic        irst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_sof = 1'b0;
  logic        in_eol = 1'b0;
  logic        out_ready = 1'b1;
  logic [35:0] in_data = '0;

  logic        ra, rb, rc, ova, ovb, ovc;
  logic [29:0] oda;
  logic [23:0] odb, odc;
  logic        sofa, sofb, sofc, eola, eolb, eolc, sata, satb, satc;
  logic [15:0] fca, fcb, fcc;

  always #5 clk = ~clk;

  dog_pyramid_stream #(.NUM_SCALES(4), .DATA_W(9), .OUT_W(10), .ABS_MODE(0)) u_a (
    .iclk(clk), .irst(irst), .in_valid(in_valid), .in_ready(ra), .in_data(in_data),
    .in_sof(in_sof), .in_eol(in_eol), .out_valid(ova), .out_ready(out_ready),
    .out_data(oda), .out_sof(sofa), .out_eol(eola), .out_sat(sata), .frame_cnt(fca));

  dog_pyramid_stream #(.NUM_SCALES(4), .DATA_W(9), .OUT_W(8), .ABS_MODE(0)) u_b (
    .iclk(clk), .irst(irst), .in_valid(in_valid), .in_ready(rb), .in_data(in_data),
    .in_sof(in_sof), .in_eol(in_eol), .out_valid(ovb), .out_ready(out_ready),
    .out_data(odb), .out_sof(sofb), .out_eol(eolb), .out_sat(satb), .frame_cnt(fcb));

  dog_pyramid_stream #(.NUM_SCALES(4), .DATA_W(9), .OUT_W(8), .ABS_MODE(1)) u_c (
    .iclk(clk), .irst(irst), .in_valid(in_valid), .in_ready(rc), .in_data(in_data),
    .in_sof(in_sof), .in_eol(in_eol), .out_valid(ovc), .out_ready(out_ready),
    .out_data(odc), .out_sof(sofc), .out_eol(eolc), .out_sat(satc), .frame_cnt(fcc));

  typedef struct {
    logic [29:0] da; logic sa;
    logic [23:0] db; logic sb;
    logic [23:0] dc; logic sc;
    logic sof; logic eol;
  } exp_t;

  typedef struct {
    logic [35:0] din; logic sof; logic eol;
    logic [29:0] da; logic sa;
    logic [23:0] db; logic sb;
    logic [23:0] dc; logic sc;
  } vec_t;

  exp_t        qa[$], qb[$], qc[$];
  exp_t        cur_exp;
  vec_t        tbl[6];
  int          n_cmp, n_err, pop_a;
  logic [15:0] exp_fc;
  logic        stall_a;
  logic [32:0] hold_a;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
    end
  endfunction

  // Reference formatting from integer arithmetic
  function automatic logic [29:0] fmt(logic [35:0] din, int ow, bit absm, output logic sat);
    int d, v, hi, lo;
    logic [29:0] r;
    r = '0;
    sat = 1'b0;
    for (int k = 0; k < 3; k++) begin
      d = int'(din[k*9+9 +: 9]) - int'(din[k*9 +: 9]);
      if (absm) begin
        v  = (d < 0) ? -d : d;
        hi = (1 << ow) - 1;
        if (v > hi) begin v = hi; sat = 1'b1; end
      end else begin
        hi = (1 << (ow - 1)) - 1;
        lo = -(1 << (ow - 1));
        v  = d;
        if (d > hi) begin v = hi; sat = 1'b1; end
        else if (d < lo) begin v = lo; sat = 1'b1; end
      end
      r = r | (30'(v & ((1 << ow) - 1)) << (k * ow));
    end
    return r;
  endfunction

  function automatic exp_t model(logic [35:0] din, logic sof, logic eol);
    exp_t e;
    logic s;
    e.da = fmt(din, 10, 1'b0, s);       e.sa = s;
    e.db = 24'(fmt(din, 8, 1'b0, s));   e.sb = s;
    e.dc = 24'(fmt(din, 8, 1'b1, s));   e.sc = s;
    e.sof = sof;
    e.eol = eol;
    return e;
  endfunction

  function automatic exp_t to_exp(vec_t v);
    exp_t e;
    e.da = v.da; e.sa = v.sa; e.db = v.db; e.sb = v.sb;
    e.dc = v.dc; e.sc = v.sc; e.sof = v.sof; e.eol = v.eol;
    return e;
  endfunction

  // Present one beat until accepted; returns 1 ns after the accepting edge
  task automatic drive(logic [35:0] din, logic sof, logic eol, exp_t e);
    int t;
    logic acc;
    cur_exp  = e;
    in_data  = din;
    in_sof   = sof;
    in_eol   = eol;
    in_valid = 1'b1;
    acc = 1'b0;
    t = 0;
    while (!acc && t < 100) begin
      @(negedge clk);
      acc = ra;
      @(posedge clk);
      #1;
      t++;
    end
    if (!acc) chk("accept_timeout", 64'(acc), 64'd1);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_eol   = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((qa.size() + qb.size() + qc.size()) != 0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain_left", 64'(qa.size() + qb.size() + qc.size()), 64'd0);
  endtask

  // Scoreboard: push on input acceptance, pop on output transfer
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (irst) begin
        qa.delete(); qb.delete(); qc.delete();
        exp_fc  = '0;
        stall_a = 1'b0;
      end else begin
        chk("frame_cnt", 64'(fca), 64'(exp_fc));
        if (stall_a) begin
          chk("hold_valid", 64'(ova), 64'd1);
          chk("hold_beat", 64'({sata, sofa, eola, oda}), 64'(hold_a));
        end
        stall_a = ova && !out_ready;
        hold_a  = {sata, sofa, eola, oda};
        if (in_valid && ra) begin
          qa.push_back(cur_exp);
          if (in_sof) exp_fc = exp_fc + 16'd1;
        end
        if (in_valid && rb) qb.push_back(cur_exp);
        if (in_valid && rc) qc.push_back(cur_exp);
        if (ova && out_ready) begin
          if (qa.size() == 0) chk("unexpected_beat_a", 64'd1, 64'd0);
          else begin
            e = qa.pop_front();
            chk("data_a", 64'(oda), 64'(e.da));
            chk("sat_a", 64'(sata), 64'(e.sa));
            chk("sof_a", 64'(sofa), 64'(e.sof));
            chk("eol_a", 64'(eola), 64'(e.eol));
            pop_a++;
          end
        end
        if (ovb && out_ready) begin
          if (qb.size() == 0) chk("unexpected_beat_b", 64'd1, 64'd0);
          else begin
            e = qb.pop_front();
            chk("data_b", 64'(odb), 64'(e.db));
            chk("sat_b", 64'(satb), 64'(e.sb));
            chk("sof_b", 64'(sofb), 64'(e.sof));
          end
        end
        if (ovc && out_ready) begin
          if (qc.size() == 0) chk("unexpected_beat_c", 64'd1, 64'd0);
          else begin
            e = qc.pop_front();
            chk("data_c", 64'(odc), 64'(e.dc));
            chk("sat_c", 64'(satc), 64'(e.sc));
            chk("eol_c", 64'(eolc), 64'(e.eol));
          end
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required $finish earlier");
    $fatal(1);
  end

  initial begin
    logic [35:0] din;
    logic        saw_block;
    int          base, rem, cyc;

    n_cmp = 0; n_err = 0; pop_a = 0;
    exp_fc = '0; stall_a = 1'b0; hold_a = '0;

    // din = {G3, G2, G1, G0}
    tbl[0] = '{{9'd400, 9'd120, 9'd150, 9'd100}, 1'b1, 1'b0,
               {10'h118, 10'h3E2, 10'h032}, 1'b0,
               {8'h7F, 8'hE2, 8'h32}, 1'b1,
               {8'hFF, 8'h1E, 8'h32}, 1'b1};
    tbl[1] = '{{9'd0, 9'd0, 9'd0, 9'd511}, 1'b0, 1'b0,
               {10'h000, 10'h000, 10'h201}, 1'b0,
               {8'h00, 8'h00, 8'h80}, 1'b1,
               {8'h00, 8'h00, 8'hFF}, 1'b1};
    tbl[2] = '{{9'd0, 9'd511, 9'd511, 9'd0}, 1'b0, 1'b0,
               {10'h201, 10'h000, 10'h1FF}, 1'b0,
               {8'h80, 8'h00, 8'h7F}, 1'b1,
               {8'hFF, 8'h00, 8'hFF}, 1'b1};
    tbl[3] = '{{9'd10, 9'd10, 9'd10, 9'd10}, 1'b0, 1'b1,
               30'h0, 1'b0, 24'h0, 1'b0, 24'h0, 1'b0};
    tbl[4] = '{{9'd128, 9'd0, 9'd127, 9'd0}, 1'b0, 1'b0,
               {10'h080, 10'h381, 10'h07F}, 1'b0,
               {8'h7F, 8'h81, 8'h7F}, 1'b1,
               {8'h80, 8'h7F, 8'h7F}, 1'b0};
    tbl[5] = '{{9'd44, 9'd300, 9'd172, 9'd300}, 1'b0, 1'b0,
               {10'h300, 10'h080, 10'h380}, 1'b0,
               {8'h80, 8'h7F, 8'h80}, 1'b1,
               {8'hFF, 8'h80, 8'h80}, 1'b1};

    fork
      monitor();
    join_none

    // Reset and idle
    irst = 1'b1;
    @(posedge clk); #1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_in_ready", 64'(ra), 64'd1);
      chk("rst_out_valid", 64'(ova), 64'd0);
      chk("rst_out_data", 64'(oda), 64'd0);
      chk("rst_frame_cnt", 64'(fca), 64'd0);
      @(posedge clk); #1;
    end
    irst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_in_ready", 64'(ra), 64'd1);
      chk("idle_out_valid", 64'(ova), 64'd0);
      @(posedge clk); #1;
    end

    // Table vectors, back to back
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) drive(tbl[i].din, tbl[i].sof, tbl[i].eol, to_exp(tbl[i]));
    wait_drain();

    // Backpressure: 8 beats, out_ready low for 5 cycles after 3
    base = pop_a;
    saw_block = 1'b0;
    rem = 0;
    cyc = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          din = {9'(16*i + 200), 9'(16*i + 3), 9'(16*i + 40), 9'(16*i)};
          drive(din, i == 0, i == 7, model(din, i == 0, i == 7));
        end
      end
      begin
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          if (!ra) saw_block = 1'b1;
          @(posedge clk); #1;
        end
        rem = 8 - (pop_a - base);
        out_ready = 1'b1;
        while ((pop_a - base) < 8 && cyc < 40) begin
          @(posedge clk);
          cyc++;
        end
        #1;
      end
    join
    chk("bp_in_ready_fell", 64'(saw_block), 64'd1);
    chk("bp_drain_cycles", 64'(cyc), 64'(rem));
    chk("bp_beats_out", 64'(pop_a - base), 64'd8);
    wait_drain();

    // Mid-stream reset with two beats in flight
    din = {9'd5, 9'd300, 9'd7, 9'd100};
    drive(din, 1'b1, 1'b0, model(din, 1'b1, 1'b0));
    din = {9'd50, 9'd60, 9'd70, 9'd80};
    drive(din, 1'b0, 1'b1, model(din, 1'b0, 1'b1));
    irst = 1'b1;
    @(posedge clk); #1;
    irst = 1'b0;
    @(negedge clk);
    chk("mrst_out_valid", 64'(ova), 64'd0);
    chk("mrst_frame_cnt", 64'(fca), 64'd0);
    @(posedge clk); #1;

    // Three sof beats, the third offered only while the pipe is full
    out_ready = 1'b0;
    din = {9'd1, 9'd2, 9'd3, 9'd4};
    drive(din, 1'b1, 1'b0, model(din, 1'b1, 1'b0));
    din = {9'd400, 9'd3, 9'd300, 9'd9};
    drive(din, 1'b1, 1'b0, model(din, 1'b1, 1'b0));
    din = {9'd11, 9'd22, 9'd33, 9'd44};
    cur_exp  = model(din, 1'b1, 1'b0);
    in_data  = din;
    in_sof   = 1'b1;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("full_in_ready", 64'(ra), 64'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
    chk("sof_count_two", 64'(fca), 64'd2);
    out_ready = 1'b1;
    wait_drain();
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
